filt_stim_gen: RTL and testbench

Synthesizable stimulus source that produces bursts of 18-bit signed (1s17) test samples for the team's FIR filter blocks. It drives their `x_in` port at a fixed sample rate of one sample every `DIV` clocks. A burst is one of four patterns: impulse, step, saturating ramp, or square wave. A `sam_en` strobe marks each new sample, so the same block also feeds downstream capture/checker logic in on-chip filter self-test.

---
 rtl/filt_stim_gen.sv | 162 ++++++++++++++++
 tb/tb_filt_stim_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/filt_stim_gen.sv
// Burst stimulus source for FIR filter blocks: impulse, step, saturating ramp
// or square wave, one sample every DIV clocks, LEN samples per burst.
module filt_stim_gen #(
  parameter int WIDTH = 18,
  parameter int DIV   = 4,
  parameter int LEN   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] amp,
  input  logic [7:0]       half_per,
  output logic [WIDTH-1:0] x_out,
  output logic             sam_en,
  output logic             busy,
  output logic             done
);

  localparam int DC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int N_W  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DIV - 1);
  localparam logic [N_W-1:0]  N_LAST  = N_W'(LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  // Clip a WIDTH+1 bit result back to WIDTH bits; overflow shows as a
  // disagreement between the two top bits.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH:0] v);
    if (v[WIDTH] != v[WIDTH-1])
      sat = v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sat = v[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] a);
    logic signed [WIDTH:0] ext;
    ext = {a[WIDTH-1], a};
    neg_sat = sat(-ext);
  endfunction

  state_t                  state_q, state_d;
  logic [DC_W-1:0]         dc_q, dc_d;
  logic [N_W-1:0]          n_q, n_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic                    sam_en_q, sam_en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [1:0]              mode_q, mode_d;
  logic signed [WIDTH-1:0] amp_q, amp_d;
  logic [7:0]              hp_q, hp_d;
  logic [7:0]              sq_cnt_q, sq_cnt_d;
  logic                    sq_neg_q, sq_neg_d;

  logic                    sq_flip;
  logic                    sq_neg_nxt;
  logic signed [WIDTH-1:0] ramp_nxt;
  logic signed [WIDTH-1:0] x_nxt;

  assign sq_flip    = (sq_cnt_q == hp_q - 8'd1);
  assign sq_neg_nxt = sq_neg_q ^ sq_flip;
  assign ramp_nxt   = sat({x_q[WIDTH-1], x_q} + {amp_q[WIDTH-1], amp_q});

  always_comb begin
    x_nxt = '0;
    case (mode_q)
      2'd0: x_nxt = '0;
      2'd1: x_nxt = amp_q;
      2'd2: x_nxt = ramp_nxt;
      default: x_nxt = sq_neg_nxt ? neg_sat(amp_q) : amp_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    dc_d     = dc_q;
    n_d      = n_q;
    x_d      = x_q;
    sam_en_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mode_d   = mode_q;
    amp_d    = amp_q;
    hp_d     = hp_q;
    sq_cnt_d = sq_cnt_q;
    sq_neg_d = sq_neg_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d  = RUN;
          mode_d   = mode;
          amp_d    = amp;
          hp_d     = (half_per == 8'd0) ? 8'd1 : half_per;
          dc_d     = '0;
          n_d      = '0;
          sq_cnt_d = '0;
          sq_neg_d = 1'b0;
          // Every pattern except the ramp opens with +amp.
          x_d      = (mode == 2'd2) ? '0 : amp;
          sam_en_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      default: begin
        if (dc_q == DC_LAST) begin
          dc_d = '0;
          if (n_q == N_LAST) begin
            state_d = IDLE;
            x_d     = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            n_d      = n_q + 1'b1;
            x_d      = x_nxt;
            sam_en_d = 1'b1;
            sq_cnt_d = sq_flip ? 8'd0 : sq_cnt_q + 8'd1;
            sq_neg_d = sq_neg_nxt;
          end
        end else begin
          dc_d = dc_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dc_q     <= '0;
      n_q      <= '0;
      x_q      <= '0;
      sam_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= '0;
      amp_q    <= '0;
      hp_q     <= '0;
      sq_cnt_q <= '0;
      sq_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dc_q     <= dc_d;
      n_q      <= n_d;
      x_q      <= x_d;
      sam_en_q <= sam_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
      amp_q    <= amp_d;
      hp_q     <= hp_d;
      sq_cnt_q <= sq_cnt_d;
      sq_neg_q <= sq_neg_d;
    end
  end

  assign x_out  = x_q;
  assign sam_en = sam_en_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_filt_stim_gen.sv
// Directed bench for filt_stim_gen: three instances cover DIV=4/LEN=8,
// DIV=1/LEN=8 and DIV=1/LEN=1.
module tb_filt_stim_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [17:0] amp;
  logic [7:0]  half_per;
  logic        start_i [3];
  logic [17:0] x_o     [3];
  logic        se_o    [3];
  logic        bz_o    [3];
  logic        dn_o    [3];

  logic [17:0] exp_s [8];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  filt_stim_gen #(.WIDTH(18), .DIV(4), .LEN(8)) u_a (
    .clk(clk), .reset(reset), .start(start_i[0]), .mode(mode), .amp(amp),
    .half_per(half_per), .x_out(x_o[0]), .sam_en(se_o[0]), .busy(bz_o[0]),
    .done(dn_o[0]));

  filt_stim_gen #(.WIDTH(18), .DIV(1), .LEN(8)) u_b (
    .clk(clk), .reset(reset), .start(start_i[1]), .mode(mode), .amp(amp),
    .half_per(half_per), .x_out(x_o[1]), .sam_en(se_o[1]), .busy(bz_o[1]),
    .done(dn_o[1]));

  filt_stim_gen #(.WIDTH(18), .DIV(1), .LEN(1)) u_c (
    .clk(clk), .reset(reset), .start(start_i[2]), .mode(mode), .amp(amp),
    .half_per(half_per), .x_out(x_o[2]), .sam_en(se_o[2]), .busy(bz_o[2]),
    .done(dn_o[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] obs(input int id);
    obs = {x_o[id], se_o[id], bz_o[id], dn_o[id]};
  endfunction

  // One burst, checked every cycle as {x_out, sam_en, busy, done}.
  task automatic burst(input int id, input int div, input int len, input int pulse_at,
                       input string nm);
    logic [20:0] exp_v;
    @(negedge clk) start_i[id] = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= len * div; c++) begin
      start_i[id] = (c == pulse_at);
      if (c < len * div)
        exp_v = {exp_s[c / div], (c % div == 0), 1'b1, 1'b0};
      else
        exp_v = {18'h0, 3'b001};
      chk($sformatf("%s.c%0d", nm, c), 32'(obs(id)), 32'(exp_v));
      @(negedge clk);
    end
    start_i[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2;
    logic prev_bz;
    reset    = 1'b1;
    mode     = 2'd0;
    amp      = '0;
    half_per = 8'd1;
    for (int i = 0; i < 3; i++) start_i[i] = 1'b0;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("rst.in%0d", i), 32'(obs(i)), 32'h0);
    reset = 1'b0;
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    // start was asserted in the same cycle reset dropped, so it is a real request
    repeat (40) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("idle.in%0d", i), 32'(obs(i)), 32'h0);

    // Impulse, DIV=4 LEN=8
    mode = 2'd0; amp = 18'h0FFFF;
    exp_s = '{18'h0FFFF, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0};
    burst(0, 4, 8, -1, "imp");

    // Ramp saturating upward and downward, DIV=1
    mode = 2'd2; amp = 18'h10000;
    exp_s = '{18'h0, 18'h10000, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF};
    burst(1, 1, 8, -1, "rampp");
    amp = 18'h30000;
    exp_s = '{18'h0, 18'h30000, 18'h20000, 18'h20000, 18'h20000, 18'h20000, 18'h20000, 18'h20000};
    burst(1, 1, 8, -1, "rampn");

    // Square with the most negative amplitude
    mode = 2'd3; amp = 18'h20000; half_per = 8'd2;
    exp_s = '{18'h20000, 18'h20000, 18'h1FFFF, 18'h1FFFF, 18'h20000, 18'h20000, 18'h1FFFF, 18'h1FFFF};
    burst(1, 1, 8, -1, "sq2");
    half_per = 8'd0;
    exp_s = '{18'h20000, 18'h1FFFF, 18'h20000, 18'h1FFFF, 18'h20000, 18'h1FFFF, 18'h20000, 18'h1FFFF};
    burst(1, 1, 8, -1, "sq0");
    amp = 18'h00100; half_per = 8'd3;
    exp_s = '{18'h00100, 18'h00100, 18'h00100, 18'h3FF00, 18'h3FF00, 18'h3FF00, 18'h00100, 18'h00100};
    burst(0, 4, 8, -1, "sq3");

    // Step with mid-burst start pulse, which must be ignored
    mode = 2'd1; amp = 18'h00ABC;
    exp_s = '{18'h00ABC, 18'h00ABC, 18'h00ABC, 18'h00ABC, 18'h00ABC, 18'h00ABC, 18'h00ABC, 18'h00ABC};
    burst(0, 4, 8, 13, "midst");

    // Step, DIV=1 LEN=1
    amp = 18'h12345;
    exp_s[0] = 18'h12345;
    burst(2, 1, 1, -1, "len1");

    // Start held high: first-sample spacing between bursts
    mode = 2'd1; amp = 18'h00005;
    t1 = -1; t2 = -1; prev_bz = 1'b0;
    @(negedge clk) start_i[0] = 1'b1;
    for (int c = 0; c < 80 && t2 < 0; c++) begin
      @(negedge clk);
      if (se_o[0] && !prev_bz) begin
        if (t1 < 0) t1 = c;
        else t2 = c;
      end
      prev_bz = bz_o[0];
    end
    start_i[0] = 1'b0;
    chk("b2b.first", 32'(t1), 32'd0);
    chk("b2b.gap", 32'(t2 - t1), 32'd33);
    for (int c = 0; c < 40 && bz_o[0]; c++) @(negedge clk);
    chk("b2b.end", 32'(obs(0)), 32'h1);
    @(negedge clk);
    chk("b2b.idle", 32'(obs(0)), 32'h0);

    // Reset during sample 3 of a ramp, then a full burst from x[0]
    mode = 2'd2; amp = 18'h00100;
    @(negedge clk) start_i[0] = 1'b1;
    @(negedge clk) start_i[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("rmid.pre", 32'(obs(0)), 32'({18'h00300, 3'b110}));
    #2 reset = 1'b1;
    #1 chk("rmid.async", 32'(obs(0)), 32'h0);
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rmid.nodone%0d", c), 32'(obs(0)), 32'h0);
    end
    exp_s = '{18'h0, 18'h00100, 18'h00200, 18'h00300, 18'h00400, 18'h00500, 18'h00600, 18'h00700};
    burst(0, 4, 8, -1, "rpost");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
